// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode encodings, FSM states and engine modes.
package alu_pkg;

    localparam int WIDTH_DEF = 32;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_MULU = 3'b011;
    localparam logic [2:0] OP_DIVU = 3'b100;
    localparam logic [2:0] OP_REMU = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b110;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic {IDLE, RUN} state_t;
    typedef enum logic {MODE_MUL, MODE_DIV} mode_t;

    function automatic logic is_div(input logic [2:0] op);
        return (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/mul_div_iter.sv
// Iterative engine: shift-add unsigned multiply or restoring unsigned divide, one bit per step.
module mul_div_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  mode_t            mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             step_en,
    output logic             last_step,
    output logic [WIDTH-1:0] quot_prod,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    mode_t            mode_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;    // product accumulator / partial remainder
    logic [WIDTH-1:0] opnd;   // multiplicand (shifted left) / divisor
    logic [WIDTH-1:0] shreg;  // multiplier (shifted right) / dividend becoming quotient

    logic [WIDTH-1:0] acc_mul;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             qbit;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH-1:0] quo_n;

    // Outputs are the values after the step being performed this cycle, so the
    // top level can capture the final answer on the same edge as the last step.
    always_comb begin
        acc_mul = acc + (shreg[0] ? opnd : '0);
        shifted = {acc, shreg[WIDTH-1]};
        diff    = shifted - {1'b0, opnd};
        qbit    = ~diff[WIDTH];
        rem_n   = qbit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quo_n   = {shreg[WIDTH-2:0], qbit};
    end

    assign last_step = (cnt == CW'(WIDTH - 1));
    assign quot_prod = (mode_q == MODE_MUL) ? acc_mul : quo_n;
    assign remainder = rem_n;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_MUL;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            shreg  <= '0;
        end else if (load) begin
            mode_q <= mode;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= (mode == MODE_MUL) ? a : b;
            shreg  <= (mode == MODE_MUL) ? b : a;
        end else if (step_en) begin
            cnt <= cnt + 1'b1;
            if (mode_q == MODE_MUL) begin
                acc   <= acc_mul;
                opnd  <= opnd << 1;
                shreg <= shreg >> 1;
            end else begin
                acc   <= rem_n;
                shreg <= quo_n;
            end
        end
    end

endmodule

// File: rtl/alu_multiciclo.sv
// Multi-cycle ALU: single-cycle logic/add/sub/slt, iterative MULU/DIVU/REMU with start/busy/done.
module alu_multiciclo
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    state_t           state, state_n;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] fast_res;
    logic [WIDTH-1:0] result_n;
    logic             done_n;
    logic             dbz_n;
    logic             load;
    logic             step_en;
    mode_t            mode;
    logic             last_step;
    logic [WIDTH-1:0] quot_prod;
    logic [WIDTH-1:0] remainder;

    mul_div_iter #(.WIDTH(WIDTH)) u_engine (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .mode      (mode),
        .a         (a),
        .b         (b),
        .step_en   (step_en),
        .last_step (last_step),
        .quot_prod (quot_prod),
        .remainder (remainder)
    );

    always_comb begin
        fast_res = '0;
        case (op)
            OP_AND:  fast_res = a & b;
            OP_OR:   fast_res = a | b;
            OP_ADD:  fast_res = a + b;
            OP_SUB:  fast_res = a - b;
            OP_SLT:  fast_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: fast_res = '0;
        endcase
    end

    // NOTE: every signal gets its default before the case so no path can
    // leave one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n  = state;
        result_n = result;
        done_n   = 1'b0;
        dbz_n    = div_by_zero;
        load     = 1'b0;
        step_en  = 1'b0;
        mode     = MODE_MUL;
        case (state)
            IDLE: begin
                if (start) begin
                    dbz_n = 1'b0;
                    if (is_div(op) && (b == '0)) begin
                        result_n = (op == OP_DIVU) ? '1 : a;
                        dbz_n    = 1'b1;
                        done_n   = 1'b1;
                    end else if (op == OP_MULU || is_div(op)) begin
                        load    = 1'b1;
                        mode    = (op == OP_MULU) ? MODE_MUL : MODE_DIV;
                        state_n = RUN;
                    end else begin
                        result_n = fast_res;
                        done_n   = 1'b1;
                    end
                end
            end
            RUN: begin
                step_en = 1'b1;
                if (last_step) begin
                    result_n = (op_q == OP_REMU) ? remainder : quot_prod;
                    done_n   = 1'b1;
                    state_n  = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            op_q        <= OP_AND;
            result      <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            state       <= state_n;
            result      <= result_n;
            done        <= done_n;
            div_by_zero <= dbz_n;
            if (load) op_q <= op;
        end
    end

    assign busy = (state == RUN);
    assign zero = (result == '0);

endmodule

// File: tb/tb_alu_multiciclo.sv
// Scoreboard bench for alu_multiciclo: expectations queued at issue, compared when done pulses.
module tb_alu_multiciclo;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] result;
    logic         zero;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    typedef struct {
        logic [W-1:0] res;
        logic         dbz;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    alu_multiciclo #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .result      (result),
        .zero        (zero),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        logic [2*W-1:0] p;
        e.dbz = 1'b0;
        p     = {{W{1'b0}}, x} * {{W{1'b0}}, y};
        case (o)
            OP_AND:  e.res = x & y;
            OP_OR:   e.res = x | y;
            OP_ADD:  e.res = x + y;
            OP_SUB:  e.res = x - y;
            OP_SLT:  e.res = ($signed(x) < $signed(y)) ? 1 : 0;
            OP_MULU: e.res = p[W-1:0];
            OP_DIVU: begin e.res = (y == 0) ? {W{1'b1}} : x / y; e.dbz = (y == 0); end
            default: begin e.res = (y == 0) ? x : x % y;         e.dbz = (y == 0); end
        endcase
        return e;
    endfunction

    function automatic int latency_of(input logic [2:0] o, input logic [W-1:0] y);
        if (o == OP_MULU) return W + 1;
        if ((o == OP_DIVU || o == OP_REMU) && y != 0) return W + 1;
        return 1;
    endfunction

    // Drives one request so that the following posedge is E0; with gap=0 the
    // request goes out in the current cycle (used right after a done cycle).
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit gap);
        if (gap) @(negedge clk);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        sb.push_back(model(o, x, y));
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_lat, input bit toggle);
        exp_t e;
        int   seen;
        seen = 0;
        for (int k = 1; k <= exp_lat + 5; k++) begin
            @(negedge clk);
            if (busy && done) begin
                n_checks++; n_fails++;
                $display("FAIL %s busy_and_done k=%0d busy=%b done=%b required not both", name, k, busy, done);
            end
            if (done) begin
                seen = k;
                break;
            end
            if (exp_lat > 1) begin
                n_checks++;
                if (busy !== 1'b1) begin
                    n_fails++;
                    $display("FAIL %s busy k=%0d got %b required 1", name, k, busy);
                end
            end
            if (toggle && k <= exp_lat - 2) begin
                a     = $urandom;
                b     = $urandom;
                op    = 3'($urandom_range(0, 7));
                start = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
            end
        end
        e = sb.pop_front();
        n_checks++;
        if (seen != exp_lat) begin
            n_fails++;
            $display("FAIL %s latency got %0d required %0d", name, seen, exp_lat);
        end
        if (seen != 0) begin
            n_checks++;
            if (result !== e.res) begin
                n_fails++;
                $display("FAIL %s result got 0x%08h required 0x%08h", name, result, e.res);
            end
            n_checks++;
            if (zero !== (e.res == 0)) begin
                n_fails++;
                $display("FAIL %s zero got %b required %b", name, zero, (e.res == 0));
            end
            n_checks++;
            if (div_by_zero !== e.dbz) begin
                n_fails++;
                $display("FAIL %s div_by_zero got %b required %b", name, div_by_zero, e.dbz);
            end
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_checks++;
        if (result !== '0 || zero !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
            n_fails++;
            $display("FAIL %s got result=0x%08h zero=%b busy=%b done=%b dbz=%b required 0/1/0/0/0",
                     name, result, zero, busy, done, div_by_zero);
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        issue(o, x, y, 1'b1);
        wait_done(name, latency_of(o, y), 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = OP_AND; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset_held");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset_idle");
    endtask

    task automatic test_single_cycle();
        run_op("add", OP_ADD, 32'd2682, 32'd2583);
        run_op("sub", OP_SUB, 32'd516, 32'd963);
        run_op("slt_neg", OP_SLT, 32'hFFFF_FE41, 32'd1);
        run_op("slt_pos", OP_SLT, 32'd5, 32'hFFFF_FFFF);
        run_op("or", OP_OR, 32'hF0F0_0000, 32'h0000_0F0F);
        run_op("add_wrap", OP_ADD, 32'hFFFF_FFFF, 32'd1);
    endtask

    task automatic test_mulu();
        issue(OP_MULU, 32'd3961, 32'd731, 1'b1);
        wait_done("mulu_toggle", W + 1, 1'b1);
        run_op("mulu_wide", OP_MULU, 32'hDEAD_BEEF, 32'h1234_5679);
    endtask

    task automatic test_div();
        run_op("divu", OP_DIVU, 32'd3545, 32'd263);
        run_op("remu", OP_REMU, 32'd3545, 32'd263);
        run_op("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'd7);
        run_op("remu_small_a", OP_REMU, 32'd5, 32'd9);
    endtask

    task automatic test_div_zero();
        run_op("divu_zero", OP_DIVU, 32'd2747, 32'd0);
        run_op("remu_zero", OP_REMU, 32'd2747, 32'd0);
        run_op("dbz_clear", OP_AND, 32'hFF, 32'h0F);
    endtask

    task automatic test_back_to_back();
        issue(OP_ADD, 32'd100, 32'd23, 1'b1);
        wait_done("b2b_add", 1, 1'b0);
        issue(OP_MULU, 32'd1000, 32'd1000, 1'b0);
        wait_done("b2b_mulu", W + 1, 1'b0);
        issue(OP_REMU, 32'd1000, 32'd7, 1'b0);
        wait_done("b2b_remu", W + 1, 1'b0);
        issue(OP_SUB, 32'd7, 32'd7, 1'b0);
        wait_done("b2b_sub", 1, 1'b0);
    endtask

    task automatic test_reset_mid_op();
        exp_t discard;
        int   stray;
        stray = 0;
        run_op("pre_abort", OP_ADD, 32'd40, 32'd2);
        issue(OP_MULU, 32'd3961, 32'd731, 1'b1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("abort_reset");
        rst = 1'b0;
        discard = sb.pop_front();
        for (int k = 0; k < W + 8; k++) begin
            @(negedge clk);
            if (done || busy) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_fails++;
            $display("FAIL abort_no_done got %0d active cycles required 0 (res 0x%08h)", stray, discard.res);
        end
        run_op("after_abort_and", OP_AND, 32'hF0, 32'h3C);
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_mulu();
        test_div();
        test_div_zero();
        test_back_to_back();
        test_reset_mid_op();
        n_checks++;
        if (sb.size() != 0) begin
            n_fails++;
            $display("FAIL scoreboard_empty got %0d entries required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
